md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit in the execute stage. Accepts an M-op from the E stage,
//   holds the pipeline via md_stall for the duration of the operation, and presents the result
//   on the release cycle. It is the requester side of the hazard interface:
//   - it drives stall requests into the hazard unit;
//   - it obeys flush_e coming back from the hazard unit.
// PARAMETERS
//   DATA_WIDTH   32   operand/result width; fixed RV32, other values unsupported
// PORTS
//   clk          in   1    single clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   start_e      in   1    valid M-extension instruction in E stage this cycle
//   funct3_e     in   3    000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   src_a_e      in   32   rs1 operand, post-forwarding
//   src_b_e      in   32   rs2 operand, post-forwarding
//   flush_e      in   1    kill the op in E; abort any operation in progress
//   md_stall     out  1    stall request to hazard unit; stalls F, D and E
//   md_done      out  1    md_result valid this cycle; the instruction leaves E at the end of this cycle
//   md_result    out  32   result of the M-op
// BEHAVIOUR
//   Reset: state=IDLE; md_stall=0, md_done=0, md_result=0; all internal registers cleared.
//   FSM states: IDLE, MUL, DIV, DONE.
//   IDLE
//     - start_e & !flush_e: latch operands and funct3, cnt=0.
//     - md_stall=1 combinationally in this same cycle (cycle 0).
//     - Next state MUL for funct3[2]=0, DIV for funct3[2]=1.
//     - Div-by-zero and signed overflow go straight to DONE.
//   MUL: radix-2 shift-add on |a| and |b|, 64-bit accumulator.
//     - One bit per cycle, 32 cycles (cnt 0..31); md_stall=1 throughout.
//     - Operand treatment: MULH signs both operands; MULHSU signs a only; MUL and MULHU treat both unsigned.
//     - MUL low 32 bits are identical signed or unsigned.
//   DIV: restoring divide on |a| and |b|; 32 cycles, md_stall=1 throughout.
//     - Signed ops: negate the quotient if the operand signs differ.
//     - Signed ops: the remainder takes the sign of the dividend.
//   DONE
//     - md_stall=0, md_done=1, md_result valid; the pipeline advances at the end of this cycle.
//     - Unconditional transition to IDLE. start_e seen in DONE is never re-accepted.
//   Result selection
//     - MUL: low word of the product.
//     - MULH, MULHSU, MULHU: high word of the product.
//     - DIV, DIVU: quotient.
//     - REM, REMU: remainder.
//   Latency, normal op: start in cycle 0, iteration in cycles 1..32, DONE in cycle 33.
//     The op occupies E for 34 cycles.
//   Latency, special cases: start in cycle 0, DONE in cycle 1.
//   Special cases (RISC-V spec):
//     - b==0, DIV/DIVU: quotient = 0xFFFFFFFF.
//     - b==0, REM/REMU: remainder = a.
//     - a==0x80000000, b==0xFFFFFFFF, DIV: quotient = 0x80000000.
//     - a==0x80000000, b==0xFFFFFFFF, REM: remainder = 0.
//   flush_e
//     - In any state: next state IDLE; md_stall deasserts that same cycle; no md_done.
//     - Same cycle as start_e in IDLE: the start is ignored.
//   start_e=0 while in MUL/DIV: ignored; the operation runs from its latched copies.
//   Operand changes after cycle 0: ignored.
//   md_result is registered. It holds its last value outside DONE and is qualified only by md_done.
//   Reset asserted mid-operation: immediate return to IDLE with all outputs 0.
// STRUCTURE
//   Shared include md_defs.vh:
//     - funct3 localparams (F3_MUL..F3_REMU);
//     - state encodings;
//     - ITER_CNT=32.
//   Natural sub-module md_iter_core:
//     - the shared 64-bit shift/add-subtract datapath with a mode select;
//     - md_unit keeps the FSM, sign fix-up and special-case detection.
//   md_stall is ORed into the hazard unit's stall_f/stall_d and into a new stall_e.
// TESTING
//   1. MUL a=7, b=6 -> md_stall high cycles 0..32, md_done in cycle 33, md_result=42.
//   2. MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000. MULHU, same operands -> 0xFFFFFFFE.
//   3. DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM, same operands -> 0xFFFFFFFF (-1).
//   4. DIVU a=5, b=0 -> md_done in cycle 1, md_result=0xFFFFFFFF.
//      REM a=0x80000000, b=-1 -> md_result=0 in cycle 1.
//   5. Start MULHSU, assert flush_e in cycle 10 -> md_stall=0 in cycle 10, IDLE in cycle 11, no md_done.
//      Next start behaves normally.
//   6. Back-to-back ops, start_e held high -> a new op is accepted only in the cycle after DONE.
//      Assert rst in cycle 5 -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared funct3 codes, FSM states and helpers for the M-extension unit
package md_unit_pkg;

  localparam int ITER_CNT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - shared 64-bit shift-add / restoring-divide datapath, one bit per step
module md_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [63:0] acc_nxt
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;

  // Upper word is partial product / partial remainder; lower word is multiplier / quotient.
  always_comb begin
    sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    shifted = {acc_q[63:32], acc_q[31]};
    ge      = shifted >= {1'b0, b_q};
    if (div_mode) begin
      acc_nxt = {(ge ? 32'(shifted - {1'b0, b_q}) : shifted[31:0]), acc_q[30:0], ge};
    end else begin
      acc_nxt = {sum, acc_q[31:1]};
    end
    acc_d = acc_q;
    b_d   = b_q;
    if (load) begin
      acc_d = {32'd0, a_in};
      b_d   = b_in;
    end else if (step) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide unit with pipeline stall and flush handling
module md_unit
  import md_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_e,
  input  logic [2:0]            funct3_e,
  input  logic [DATA_WIDTH-1:0] src_a_e,
  input  logic [DATA_WIDTH-1:0] src_b_e,
  input  logic                  flush_e,
  output logic                  md_stall,
  output logic                  md_done,
  output logic [DATA_WIDTH-1:0] md_result
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;
  logic [31:0] res_q, res_d;

  logic        load, step, stall, done;
  logic        signed_a, signed_b, neg_e, div_zero, div_ovf;
  logic [63:0] acc_nxt, fix64;
  logic [31:0] word;

  always_comb begin
    signed_a = (funct3_e == F3_MULH) || (funct3_e == F3_MULHSU) ||
               (funct3_e == F3_DIV)  || (funct3_e == F3_REM);
    signed_b = (funct3_e == F3_MULH) || (funct3_e == F3_DIV) || (funct3_e == F3_REM);
    case (funct3_e)
      F3_MULH, F3_DIV:   neg_e = src_a_e[31] ^ src_b_e[31];
      F3_MULHSU, F3_REM: neg_e = src_a_e[31];
      default:           neg_e = 1'b0;
    endcase
    div_zero = funct3_e[2] && (src_b_e == 32'd0);
    div_ovf  = funct3_e[2] && !funct3_e[0] &&
               (src_a_e == 32'h8000_0000) && (src_b_e == 32'hFFFF_FFFF);
  end

  // Product sign is fixed on 64 bits; quotient/remainder sign on the selected word.
  always_comb begin
    fix64 = (!f3_q[2] && neg_q) ? -acc_nxt : acc_nxt;
    word  = (f3_q == F3_MUL || f3_q == F3_DIV || f3_q == F3_DIVU) ? fix64[31:0] : fix64[63:32];
    if (f3_q[2] && neg_q) word = -word;
  end

  md_iter_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .div_mode (state_q == S_DIV),
    .a_in     (mag32(src_a_e, signed_a)),
    .b_in     (mag32(src_b_e, signed_b)),
    .acc_nxt  (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    res_d   = res_q;
    load    = 1'b0;
    step    = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          stall = 1'b1;
          load  = 1'b1;
          f3_d  = funct3_e;
          neg_d = neg_e;
          cnt_d = '0;
          if (div_zero) begin
            res_d   = funct3_e[1] ? src_a_e : 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = funct3_e[1] ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            state_d = funct3_e[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        stall = 1'b1;
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_CNT - 1)) begin
          res_d   = word;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_e) begin
      state_d = S_IDLE;
      stall   = 1'b0;
      done    = 1'b0;
      load    = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign md_stall  = stall & ~rst;
  assign md_done   = done;
  assign md_result = res_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start_e;
  logic [2:0]  funct3_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        flush_e;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;

  int total = 0;
  int bad   = 0;

  md_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_e   (start_e),
    .funct3_e  (funct3_e),
    .src_a_e   (src_a_e),
    .src_b_e   (src_b_e),
    .flush_e   (flush_e),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int cyc;
    int stall_bad;
    exp = ref_md(f3, a, b);
    @(negedge clk);
    start_e = 1'b1; funct3_e = f3; src_a_e = a; src_b_e = b;
    #1;
    chk({tag, "_stall_c0"}, 32'(md_stall), 32'd1);
    @(negedge clk);
    start_e = 1'b0; funct3_e = 3'($urandom); src_a_e = $urandom; src_b_e = $urandom;
    cyc = 1;
    stall_bad = 0;
    while (!md_done && cyc < 40) begin
      if (!md_stall) stall_bad++;
      @(negedge clk);
      src_a_e = $urandom; src_b_e = $urandom;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(ref_latency(f3, a, b)));
    chk({tag, "_result"}, md_result, exp);
    chk({tag, "_stall_done"}, 32'(md_stall), 32'd0);
    chk({tag, "_stall_iter"}, 32'(stall_bad), 32'd0);
    @(negedge clk);
    chk({tag, "_done_clear"}, 32'(md_done), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_seen;
    rst = 1'b0; start_e = 1'b0; funct3_e = '0; src_a_e = '0; src_b_e = '0; flush_e = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_stall", 32'(md_stall), 32'd0);
    chk("reset_done", 32'(md_done), 32'd0);
    chk("reset_result", md_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(F3_MUL,    32'd7,          32'd6,          "mul_7x6");
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulh_m1");
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  "mulhu_max");
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,          "div_m7_2");
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,          "rem_m7_2");
    run_op(F3_DIVU,   32'd5,          32'd0,          "divu_by0");
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  "rem_ovf");
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  "div_ovf");
    run_op(F3_REMU,   32'd13,         32'd0,          "remu_by0");
    run_op(F3_MULHSU, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  "mulhsu_neg");

    // Flush in cycle 10 of a MULHSU.
    @(negedge clk);
    start_e = 1'b1; funct3_e = F3_MULHSU; src_a_e = 32'h1234_5678; src_b_e = 32'h9ABC_DEF0;
    @(negedge clk);
    start_e = 1'b0;
    repeat (9) @(negedge clk);
    flush_e = 1'b1;
    #1;
    chk("flush_stall_c10", 32'(md_stall), 32'd0);
    chk("flush_done_c10", 32'(md_done), 32'd0);
    @(negedge clk);
    flush_e = 1'b0;
    #1;
    chk("flush_stall_c11", 32'(md_stall), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done) done_seen++;
    end
    chk("flush_no_done", 32'(done_seen), 32'd0);
    run_op(F3_MULHSU, 32'h8765_4321, 32'h0000_0003, "after_flush");

    // Back-to-back with start_e held high, operands changed after cycle 0.
    @(negedge clk);
    start_e = 1'b1; funct3_e = F3_MUL; src_a_e = 32'd3; src_b_e = 32'd5;
    @(negedge clk);
    src_a_e = 32'd9; src_b_e = 32'd4;
    repeat (32) @(negedge clk);
    chk("b2b_done1", 32'(md_done), 32'd1);
    chk("b2b_stall_done1", 32'(md_stall), 32'd0);
    chk("b2b_result1", md_result, 32'd15);
    @(negedge clk);
    chk("b2b_restart_stall", 32'(md_stall), 32'd1);
    chk("b2b_restart_done", 32'(md_done), 32'd0);
    repeat (33) @(negedge clk);
    chk("b2b_done2", 32'(md_done), 32'd1);
    chk("b2b_result2", md_result, 32'd36);
    repeat (6) @(negedge clk);
    chk("rst_pre_stall", 32'(md_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(md_stall), 32'd0);
    chk("rst_mid_done", 32'(md_done), 32'd0);
    chk("rst_mid_result", md_result, 32'd0);
    start_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_post_done", 32'(md_done), 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f3, a, b, $sformatf("rand%0d_f%0d", i, f3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
